// File: rtl/inst_fetch_pkg.sv
// Shared core package: fetch FSM state encoding, the default reset PC and the
// instruction width. The control unit imports the same definitions.
package inst_fetch_pkg;

  localparam int unsigned INST_W        = 32;
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: a small FIFO holding {instruction, pc} pairs between the
// memory response and the decoder.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_inst/pc    write one entry (ignored when full)
//   pop                   remove the head entry (ignored when empty)
//   flush                 drop every entry; takes priority over push and pop
//   head_inst, head_pc    head entry, driven from registered storage only
//   valid, full           buffer non-empty / no free entry
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [31:0]       push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [INST_W-1:0] head_inst,
  output logic [31:0]       head_pc,
  output logic              valid,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [31:0]       pc_mem_q   [DEPTH];
  logic [31:0]       pc_mem_d   [DEPTH];
  logic              do_push, do_pop;

  assign valid     = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & valid;
  assign head_inst = inst_mem_q[rd_ptr_q];
  assign head_pc   = pc_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        inst_mem_d[wr_ptr_q] = push_inst;
        pc_mem_d[wr_ptr_q]   = push_pc;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory, buffers returned words with their addresses and presents them to
// decode. A consume with pc_sel set redirects the stream.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req, imem_addr, imem_gnt      request handshake (grant same cycle)
//   imem_rvalid, imem_rdata            read response, one per granted request
//   inst, inst_pc, inst_valid          buffer head to the control unit
//   inst_ready                         decode consumes the head
//   pc_sel, redirect_pc                redirect, qualified by a consume
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CORE_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              pc_sel,
  input  logic [31:0]       redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  infl_pc_q, infl_pc_d;
  logic         fifo_full;
  logic         push;
  logic         redirect;

  assign redirect  = inst_valid & inst_ready & pc_sel;
  assign imem_addr = imem_req ? pc_q : 32'h0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_pc_d = infl_pc_q;
    imem_req  = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // A redirect suppresses the request so the old pc never goes out.
        if (!fifo_full && !redirect) begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            infl_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = ~redirect;
          state_d = FETCH;
        end else if (redirect) begin
          // Response still owed by memory; it belongs to the old stream.
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) pc_d = word_align(redirect_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      infl_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_inst (imem_rdata),
    .push_pc   (infl_pc_q),
    .pop       (inst_ready),
    .flush     (redirect),
    .head_inst (inst),
    .head_pc   (inst_pc),
    .valid     (inst_valid),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        pc_sel;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC   (TB_RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  int          lat = 1;
  logic        pend;
  int          cd;
  logic [31:0] paddr;

  // per-cycle samples and logs
  logic        s_req, s_valid, s_fire;
  logic [31:0] s_addr, s_inst, s_pc;
  int          fire_cnt, cons_cnt;
  logic [31:0] last_fire_addr;
  logic [31:0] fire_log[$];
  logic [31:0] cons_log[$];
  logic [31:0] exp_q[$];

  typedef struct {
    int          lat;
    int          hold;
    logic [31:0] target;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_refill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  function automatic logic [31:0] cons_at(input int idx);
    if (idx < cons_log.size()) return cons_log[idx];
    return 32'hxxxx_xxxx;
  endfunction

  // One clock cycle: monitor/scoreboard at negedge, memory response after posedge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = inst_valid;
    s_inst  = inst;
    s_pc    = inst_pc;
    s_fire  = imem_req & imem_gnt;
    if (s_fire) begin
      fire_cnt++;
      last_fire_addr = imem_addr;
      fire_log.push_back(imem_addr);
    end
    if (inst_valid && inst_ready) begin
      cons_cnt++;
      cons_log.push_back(inst_pc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got pc %h with no expected entry", inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst, mem_word(e));
      end
      if (pc_sel) sb_refill({redirect_pc[31:2], 2'b00});
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (s_fire) begin
      pend  = 1'b1;
      cd    = lat;
      paddr = s_addr;
    end
    if (pend) begin
      cd--;
      if (cd == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int l);
    rst_n       = 1'b0;
    inst_ready  = 1'b0;
    pc_sel      = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    cd          = 0;
    lat         = l;
    fire_cnt    = 0;
    cons_cnt    = 0;
    fire_log.delete();
    cons_log.delete();
    sb_refill(TB_RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_fires(input int n, input int budget);
    int k = 0;
    while (fire_cnt < n && k < budget) begin
      step();
      k++;
    end
    if (fire_cnt < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL fire_timeout: got %0d requests expected %0d", fire_cnt, n);
    end
  endtask

  task automatic run_cons(input int n, input int budget);
    int k = 0;
    while (cons_cnt < n && k < budget) begin
      step();
      k++;
    end
    if (cons_cnt < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL cons_timeout: got %0d consumes expected %0d", cons_cnt, n);
    end
  endtask

  // Redirect while a request is outstanding; delay selects whether the
  // redirect lands before the response (DROP) or on the response cycle.
  task automatic wait_redirect(input int l, input int delay, input logic [31:0] target,
                               input logic [31:0] exp, input bit is_drop);
    int n0, c0;
    do_reset(l);
    inst_ready = 1'b0;
    run_fires(2, 40);
    repeat (delay) step();
    chk("wr_head_valid", inst_valid, 1'b1);
    inst_ready  = 1'b1;
    pc_sel      = 1'b1;
    redirect_pc = target;
    n0 = fire_cnt;
    c0 = cons_cnt;
    step();
    pc_sel = 1'b0;
    if (is_drop) begin
      step();
      chk("drop_no_req", s_req, 1'b0);
    end
    run_fires(n0 + 1, 40);
    chk("wr_next_fetch", last_fire_addr, exp);
    run_cons(c0 + 2, 40);
    chk("wr_next_inst_pc", cons_at(c0 + 1), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   k, c0;

    tbl[0] = '{lat: 1, hold: 10, target: 32'h0000_0100, exp_pc: 32'h0000_0100};
    tbl[1] = '{lat: 1, hold: 0,  target: 32'h0000_0103, exp_pc: 32'h0000_0100};
    tbl[2] = '{lat: 2, hold: 5,  target: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC};
    tbl[3] = '{lat: 3, hold: 0,  target: 32'h0000_1002, exp_pc: 32'h0000_1000};

    imem_gnt    = 1'b1;
    rst_n       = 1'b0;
    inst_ready  = 1'b0;
    pc_sel      = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    #12;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // Reset release, zero-wait memory, always ready.
    do_reset(1);
    inst_ready = 1'b1;
    step();
    chk("idle_no_req", s_req, 1'b0);
    step();
    chk("first_req", s_req, 1'b1);
    chk("first_addr", s_addr, TB_RESET_PC);
    step();
    chk("not_valid_1_after_gnt", s_valid, 1'b0);
    step();
    chk("valid_2_after_gnt", s_valid, 1'b1);
    chk("first_inst", s_inst, mem_word(32'h0));
    run_fires(4, 40);
    for (int i = 0; i < 4; i++) chk("fetch_order", fire_log[i], 32'(4 * i));

    // Backpressure: buffer fills to two, then requests stop.
    do_reset(1);
    inst_ready = 1'b0;
    repeat (10) step();
    chk("bp_two_fetches", fire_cnt, 2);
    chk("bp_valid", s_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_req_blocked", s_req, 1'b0);
    end
    chk("bp_still_two", fire_cnt, 2);
    inst_ready = 1'b1;
    run_cons(3, 30);
    chk("bp_deliver0", cons_at(0), 32'h0);
    chk("bp_deliver1", cons_at(1), 32'h4);
    chk("bp_deliver2", cons_at(2), 32'h8);

    // Table of redirects at a consume, including a full buffer and alignment.
    for (int t = 0; t < 4; t++) begin
      do_reset(tbl[t].lat);
      inst_ready = 1'b0;
      repeat (tbl[t].hold) step();
      k = 0;
      while (!inst_valid && k < 20) begin
        step();
        k++;
      end
      chk("tbl_head_valid", inst_valid, 1'b1);
      c0          = cons_cnt;
      inst_ready  = 1'b1;
      pc_sel      = 1'b1;
      redirect_pc = tbl[t].target;
      step();
      pc_sel = 1'b0;
      run_cons(c0 + 5, 80);
      chk("tbl_redirect_pc", cons_at(c0 + 1), tbl[t].exp_pc);
    end

    // Redirect in WAIT, 3-cycle memory: stale word dropped.
    wait_redirect(3, 0, 32'h0000_0040, 32'h0000_0040, 1'b1);
    // Redirect on the same cycle as imem_rvalid.
    wait_redirect(2, 1, 32'h0000_0080, 32'h0000_0080, 1'b0);

    // Reset pulsed while a request is outstanding.
    do_reset(3);
    inst_ready = 1'b1;
    run_fires(3, 60);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", inst_valid, 1'b0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_inst_pc", inst_pc, 32'h0);
    do_reset(3);
    inst_ready = 1'b1;
    run_fires(1, 20);
    chk("mid_rst_refetch", last_fire_addr, TB_RESET_PC);
    run_cons(1, 40);
    chk("mid_rst_first_inst_pc", cons_at(0), TB_RESET_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries; fixed at 2 in this revision.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, 32, word-aligned fetch address, valid while imem_req=1.
REQ-007 SHALL have port imem_gnt, input, 1, memory accepts the request in the same cycle.
REQ-008 SHALL have port imem_rvalid, input, 1, read data valid, at least 1 cycle after grant.
REQ-009 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-010 SHALL have port inst, output, 32, instruction at buffer head, to the control unit.
REQ-011 SHALL have port inst_pc, output, 32, address of inst.
REQ-012 SHALL have port inst_valid, output, 1, buffer non-empty.
REQ-013 SHALL have port inst_ready, input, 1, decode consumes head when inst_valid=1 and inst_ready=1.
REQ-014 SHALL have port pc_sel, input, 1, redirect from the control unit, qualified by a consume.
REQ-015 SHALL have port redirect_pc, input, 32, redirect target; bits [1:0] ignored and treated as 00.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, DROP.
REQ-017 SHALL spend IDLE exactly one cycle after reset release, then go to FETCH; imem_rvalid is ignored in IDLE.
REQ-018 In FETCH, SHALL assert imem_req with imem_addr=pc when the buffer has a free entry; on imem_gnt: latch pc as the in-flight address, pc<=pc+4, go to WAIT.
REQ-019 SHALL allow at most one outstanding request; imem_req=0 in WAIT and DROP.
REQ-020 In WAIT, on imem_rvalid SHALL push {in-flight address, imem_rdata} into the buffer and go to FETCH.
REQ-021 Pushed data SHALL appear on inst/inst_pc/inst_valid the cycle after imem_rvalid; minimum grant-to-inst_valid latency is 2 cycles.
REQ-022 Buffer SHALL be a 2-entry FIFO with wrap-around pointers; push and pop in the same cycle are both honoured; full blocks imem_req; there is no pop when empty.
REQ-023 A redirect occurs when inst_valid & inst_ready & pc_sel; on redirect SHALL flush all buffer entries, set pc<=redirect_pc & ~3, and deassert imem_req that cycle.
REQ-024 Redirect in FETCH SHALL return to FETCH; in WAIT without imem_rvalid SHALL go to DROP; in WAIT with imem_rvalid in the same cycle SHALL discard the data and go to FETCH.
REQ-025 In DROP, SHALL discard the next imem_rvalid data and go to FETCH.
REQ-026 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 Output and buffer pointers SHALL be registered; there SHALL be no combinational path from imem_rdata to inst.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, buffer empty, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0.
REQ-029 Reset asserted mid-fetch SHALL abandon the outstanding request; instruction memory is reset by the same rst_n.

Structure
REQ-030 SHALL place FSM state encoding, RESET_PC default and instruction width (32) in the shared core package used by the control unit.
REQ-031 SHALL implement the buffer as one sub-module, fetch_fifo, containing data and pc storage, pointers, count, and flush.

Verification
REQ-032 Bench SHALL check reset: after rst_n release with zero-wait memory and inst_ready=1 -> first imem_addr=0, inst=word@0 valid 2 cycles after grant, then addresses 4, 8, 12 in order.
REQ-033 Bench SHALL check backpressure: inst_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0 while full; on release, instructions 0 and 4 are delivered with no loss or duplication.
REQ-034 Bench SHALL check redirect while the buffer holds 2: consume with pc_sel=1 and redirect_pc=32'h100 -> next inst_pc=32'h100, stale entry never seen.
REQ-035 Bench SHALL check redirect during WAIT with 3-cycle memory latency, target 32'h40 -> stale rdata is dropped and the next delivered inst_pc=32'h40.
REQ-036 Bench SHALL check simultaneous imem_rvalid and redirect -> data discarded, next fetch at target; separately, redirect_pc=32'h103 -> fetch at 32'h100.
REQ-037 Bench SHALL check rst_n pulsed low while in WAIT -> outputs zero immediately, fetch restarts at RESET_PC.
